ring_buffer_wr_arbiter: RTL and testbench
=========================================

# ring_buffer_wr_arbiter

Round-robin, burst-locking arbiter that shares the single write port of `ring_buffer` among NUM_REQ producers (DMA read-data channels, VRSM result writers). Each producer offers beats with a valid/ready/last handshake. The arbiter grants one producer per burst, forwards its beats to `wen`/`din`, and throttles on `full_flag`. It sits directly in front of `ring_buffer`; the read side is untouched.

## Interface
- DATA_WIDTH, 32: beat width; must equal the `ring_buffer` DATA_WIDTH.
- NUM_REQ, 4: number of producers; legal range 2..16.
- MAX_BURST, 16: maximum beats per grant before forced release; legal range 1..256.
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-producer beat valid.
- req_last  input  NUM_REQ  per-producer last beat of burst; qualified by valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-producer ready; one-hot or zero.
- full_flag  input  1  from `ring_buffer`.
- wen  output  1  to `ring_buffer` write enable.
- din  output  DATA_WIDTH  to `ring_buffer` write data.
- grant_valid  output  1  a burst is granted (state BURST).
- grant_id  output  $clog2(NUM_REQ)  index of the granted producer.
- forced_release  output  1  one-cycle pulse when a grant ends on MAX_BURST without `last`.

## Operation
- State machine, 2 states:
  - IDLE: no grant.
    - If any `req_valid` is high, go to BURST. Grant the first valid index found searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
    - Clear `beat_cnt`.
  - BURST: grant held by `grant_id`.
    - `req_ready[grant_id] = !full_flag`; all other readies are 0.
    - Beat accepted when `req_valid[grant_id] && req_ready[grant_id]`.
- On acceptance:
  - `wen = 1`, `din = req_data[grant_id]`, `beat_cnt` increments.
- Burst end, on the accepting beat:
  - If `req_last` is high, or `beat_cnt == MAX_BURST-1`: next state IDLE, and `rr_ptr <= grant_id+1` (wraps to 0).
  - If the end was due to MAX_BURST with `req_last` low: `forced_release` pulses in the following cycle. The producer's remaining beats re-arbitrate as a new burst.
- Burst lock: while in BURST, if the granted producer drops `req_valid`, the grant is held with no beat and no timeout. Other producers wait.
- `wen` is never asserted while `full_flag` is high, so no write is ever dropped by `ring_buffer`.
- Outputs outside an accepted beat:
  - `wen = 0`, `din = 0`.
  - In IDLE: `req_ready = 0`, `grant_valid = 0`, `grant_id` holds its last value.
- `beat_cnt` width is $clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1 before reset to 0.

## Timing
- Reset (`rst` low, async):
  - State IDLE, `rr_ptr = 0`, `grant_id = 0`, `beat_cnt = 0`.
  - Outputs: `grant_valid = 0`, `forced_release = 0`, `req_ready = 0`, `wen = 0`, `din = 0`.
- Reset asserted mid-burst: the grant is abandoned immediately. The partially written burst stays in `ring_buffer`; the arbiter does not track it.
- Arbitration latency: `req_valid` sampled high in IDLE at edge N gives `grant_valid` and ready after edge N.
- First beat can be written at edge N+1.
- Throughput: 1 beat/cycle within a burst. There is exactly one IDLE cycle between consecutive bursts.
- `req_ready`, `wen` and `din` are combinational from state, `grant_id`, `full_flag` and the request inputs. `grant_valid`, `grant_id` and `forced_release` are registered.
- Full handling:
  - `full_flag` high stalls the granted producer with ready low.
  - When `full_flag` falls (a reader frees space), the beat completes in that same cycle.
- Single producer: even with only one producer requesting, every burst passes through IDLE for one cycle.
- Simultaneous last and MAX_BURST on one beat: treated as a normal `last` end, with no `forced_release`.

## Test plan
- Single producer 0 sends burst 1,2,3 (last on 3), `full_flag` 0:
  - `grant_valid` rises 1 cycle after valid.
  - `wen` high 3 consecutive cycles with `din` 1,2,3.
  - Back to IDLE; `rr_ptr` = 1.
- All 4 producers valid continuously with 2-beat bursts:
  - Grant order is 0,1,2,3,0.
  - Exactly one idle cycle between bursts.
  - No beat from a non-granted producer ever appears on `din`.
- Producer 2 streams 20 beats, never asserting last, MAX_BURST = 16:
  - 16 writes, then `forced_release` pulses once.
  - Producer 3 (also valid) wins the next grant, then producer 2 resumes with beats 17..20.
- `full_flag` held high for 5 cycles mid-burst:
  - `req_ready` and `wen` stay 0 during the stall, and no data is lost.
  - The stalled beat writes in the cycle `full_flag` falls.
- Granted producer 1 drops valid for 3 cycles mid-burst while producer 0 is valid:
  - The grant stays on 1.
  - Producer 0 is granted only after 1's last beat.
- Assert `rst` low mid-burst, asynchronously between edges:
  - All outputs go 0 immediately.
  - After release, the first grant searches from index 0.

Source files
------------

// File: rtl/ring_buffer_wr_arbiter_if.sv
// Producer-side and ring_buffer write-side signals of the write arbiter.
// The master modport is the producers plus ring_buffer; the slave modport is the arbiter.
interface ring_buffer_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          full_flag;
    logic                          wen;
    logic [DATA_WIDTH-1:0]         din;

    modport master (
        output req_valid, req_last, req_data, full_flag,
        input  req_ready, wen, din
    );

    modport slave (
        input  req_valid, req_last, req_data, full_flag,
        output req_ready, wen, din
    );
endinterface

// File: rtl/ring_buffer_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing the ring_buffer write port among NUM_REQ producers.
// One producer owns the port per burst; a burst ends on last or after MAX_BURST beats.
module ring_buffer_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    ring_buffer_wr_arbiter_if.slave    bus,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       forced_release
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                state, state_nxt;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       pick_id;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  any_valid;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic                  burst_end;

    // First valid index at or above ptr, wrapping; lowest offset wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_W-1:0]    ptr);
        int idx;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (valid[ID_W'(idx)]) rr_pick = ID_W'(idx);
        end
    endfunction

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign any_valid = |bus.req_valid;
    assign pick_id   = rr_pick(bus.req_valid, rr_ptr);
    assign accept    = (state == BURST) && sel_valid && !bus.full_flag;
    // Simultaneous last and MAX_BURST counts as a normal last end.
    assign burst_end = accept && (sel_last || (beat_cnt == CNT_W'(MAX_BURST - 1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = BURST;
            BURST:   if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.wen       = 1'b0;
        bus.din       = '0;
        if (state == BURST) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id == ID_W'(i)) bus.req_ready[i] = !bus.full_flag;
            end
        end
        if (accept) begin
            bus.wen = 1'b1;
            bus.din = sel_data;
        end
    end

    assign grant_valid = (state == BURST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr         <= '0;
            grant_id       <= '0;
            beat_cnt       <= '0;
            forced_release <= 1'b0;
        end else begin
            forced_release <= burst_end && !sel_last;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (any_valid) grant_id <= pick_id;
                end
                BURST: begin
                    if (burst_end) begin
                        beat_cnt <= '0;
                        rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: beat_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_ring_buffer_wr_arbiter.sv
// Bench for ring_buffer_wr_arbiter: producer queues drive the DUT and a cycle-level
// reference model of the arbitration rules predicts every output.
module tb_ring_buffer_wr_arbiter;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int MB = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         forced_release;

    always #5 clk = ~clk;

    ring_buffer_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus();

    ring_buffer_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .forced_release(forced_release)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] q_data [N][$];
    bit          q_last [N][$];
    logic [31:0] sent   [N][$];
    bit          en     [N];
    bit          full;
    bit          rnd_mode;
    int          seq;

    int          m_owner, m_gid, m_ptr, m_cnt;
    bit          m_fr;

    int          grants [$];
    logic [31:0] wlog_d [$];
    int          wlog_id[$];
    int          fr_cnt;
    bit          gv_prev;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bit ne;
            ne = (q_data[i].size() != 0);
            bus.req_valid[i]            = ne && en[i];
            bus.req_data[i*DW +: DW]    = ne ? q_data[i][0] : $urandom;
            bus.req_last[i]             = ne ? q_last[i][0] : 1'($urandom);
        end
        bus.full_flag = full;
    endtask

    task automatic push_burst(input int p, input int len, input bit with_last);
        for (int b = 0; b < len; b++) begin
            logic [31:0] d;
            d = {8'(p), 24'(seq)};
            seq++;
            q_data[p].push_back(d);
            sent[p].push_back(d);
            q_last[p].push_back(with_last && (b == len - 1));
        end
    endtask

    task automatic clear_logs();
        grants.delete();
        wlog_d.delete();
        wlog_id.delete();
        fr_cnt = 0;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            q_data[i].delete();
            q_last[i].delete();
            sent[i].delete();
            en[i] = 1'b1;
        end
    endtask

    // Asserts reset between clock edges and checks outputs collapse at once.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_wen", 64'(bus.wen), 0);
        chk("rst_din", 64'(bus.din), 0);
        chk("rst_ready", 64'(bus.req_ready), 0);
        chk("rst_gv", 64'(grant_valid), 0);
        chk("rst_fr", 64'(forced_release), 0);
        chk("rst_gid", 64'(grant_id), 0);
        m_owner = -1; m_gid = 0; m_ptr = 0; m_cnt = 0; m_fr = 1'b0;
        gv_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        full = 1'b0;
        drive();
    endtask

    task automatic step();
        logic [N-1:0] v;
        logic [N-1:0] exp_ready;
        logic [31:0]  exp_din;
        bit           acc, lst;
        @(negedge clk);
        v         = bus.req_valid;
        exp_ready = '0;
        acc       = 1'b0;
        exp_din   = '0;
        if (m_owner >= 0 && !bus.full_flag) begin
            exp_ready[m_owner] = 1'b1;
            acc = v[m_owner];
        end
        if (acc) exp_din = q_data[m_owner][0];
        chk("ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("wen", 64'(bus.wen), 64'(acc));
        chk("din", 64'(bus.din), 64'(exp_din));
        chk("grant_valid", 64'(grant_valid), 64'(m_owner >= 0));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("forced_release", 64'(forced_release), 64'(m_fr));
        chk("wen_under_full", 64'(bus.wen && bus.full_flag), 0);
        if (bus.wen) begin
            wlog_d.push_back(bus.din);
            wlog_id.push_back(int'(grant_id));
        end
        if (grant_valid && !gv_prev) grants.push_back(int'(grant_id));
        gv_prev = grant_valid;
        if (forced_release) fr_cnt++;
        @(posedge clk);
        if (m_owner < 0) begin
            m_fr = 1'b0;
            for (int k = N - 1; k >= 0; k--) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (v[idx]) begin m_owner = idx; m_gid = idx; end
            end
            m_cnt = 0;
        end else begin
            m_fr = 1'b0;
            if (acc) begin
                lst = q_last[m_owner][0];
                void'(q_data[m_owner].pop_front());
                void'(q_last[m_owner].pop_front());
                m_cnt++;
                if (lst || m_cnt == MB) begin
                    m_fr    = !lst;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end
        end
        #1;
        if (rnd_mode) begin
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(99) < 70);
            full = ($urandom_range(99) < 20);
        end
        drive();
    endtask

    task automatic run_until_empty(input int max_steps);
        int  n;
        bit  busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < max_steps) begin
            step();
            n++;
            busy = 1'b0;
            for (int i = 0; i < N; i++) if (q_data[i].size() != 0) busy = 1'b1;
        end
        chk("drain_within_budget", 64'(busy), 0);
        repeat (2) step();
    endtask

    initial begin
        seq = 1; full = 1'b0; rnd_mode = 1'b0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.full_flag = 1'b0;
        rst = 1'b1;
        clear_queues();
        clear_logs();
        #2;
        do_reset();

        // single producer 0, burst 1,2,3
        for (int b = 1; b <= 3; b++) begin
            q_data[0].push_back(32'(b));
            sent[0].push_back(32'(b));
            q_last[0].push_back(b == 3);
        end
        drive();
        run_until_empty(20);
        chk("t1_nwrites", 64'(wlog_d.size()), 3);
        for (int b = 0; b < 3 && b < wlog_d.size(); b++) chk("t1_data", 64'(wlog_d[b]), 64'(b + 1));
        // rr_ptr now 1: with 0 and 1 both asking, 1 wins
        clear_logs();
        push_burst(0, 1, 1'b1);
        push_burst(1, 1, 1'b1);
        drive();
        run_until_empty(20);
        chk("t1_ptr_next_grant", 64'(grants.size() > 0 ? grants[0] : -1), 1);

        // all producers, 2-beat bursts
        clear_queues(); clear_logs();
        do_reset();
        for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) push_burst(p, 2, 1'b1);
        drive();
        run_until_empty(100);
        chk("t2_ngrants", 64'(grants.size()), 8);
        for (int g = 0; g < 5 && g < grants.size(); g++) chk("t2_order", 64'(grants[g]), 64'(g % N));
        for (int w = 0; w < wlog_d.size(); w++) chk("t2_owner", 64'(wlog_d[w][31:24]), 64'(wlog_id[w]));

        // producer 2 streams 20 beats without last, producer 3 waiting
        clear_queues(); clear_logs();
        do_reset();
        push_burst(2, 20, 1'b0);
        push_burst(3, 2, 1'b1);
        drive();
        run_until_empty(100);
        chk("t3_fr_count", 64'(fr_cnt), 1);
        chk("t3_ngrants", 64'(grants.size()), 3);
        if (grants.size() == 3) begin
            chk("t3_g0", 64'(grants[0]), 2);
            chk("t3_g1", 64'(grants[1]), 3);
            chk("t3_g2", 64'(grants[2]), 2);
        end
        chk("t3_nwrites", 64'(wlog_d.size()), 22);
        if (wlog_d.size() == 22) begin
            chk("t3_w15", 64'(wlog_id[15]), 2);
            chk("t3_w16", 64'(wlog_id[16]), 3);
            chk("t3_w18", 64'(wlog_d[18]), 64'(sent[2][16]));
        end

        // full_flag high 5 cycles mid-burst
        clear_queues(); clear_logs();
        do_reset();
        push_burst(0, 8, 1'b1);
        drive();
        repeat (3) step();
        full = 1'b1; drive();
        repeat (5) step();
        full = 1'b0; drive();
        run_until_empty(40);
        chk("t4_nwrites", 64'(wlog_d.size()), 8);
        for (int w = 0; w < wlog_d.size() && w < 8; w++) chk("t4_data", 64'(wlog_d[w]), 64'(sent[0][w]));

        // granted producer 1 drops valid while producer 0 waits
        clear_queues(); clear_logs();
        do_reset();
        push_burst(1, 4, 1'b1);
        drive();
        step();
        push_burst(0, 2, 1'b1);
        drive();
        repeat (2) step();
        en[1] = 1'b0; drive();
        repeat (3) step();
        en[1] = 1'b1; drive();
        run_until_empty(40);
        chk("t5_ngrants", 64'(grants.size()), 2);
        if (grants.size() == 2) begin
            chk("t5_g0", 64'(grants[0]), 1);
            chk("t5_g1", 64'(grants[1]), 0);
        end

        // async reset mid-burst, then search restarts at 0
        clear_queues(); clear_logs();
        do_reset();
        push_burst(2, 6, 1'b1);
        drive();
        repeat (3) step();
        chk("t6_in_burst", 64'(grant_valid), 1);
        #3;
        clear_logs();
        push_burst(1, 1, 1'b1);
        do_reset();
        run_until_empty(40);
        chk("t6_first_grant", 64'(grants.size() > 0 ? grants[0] : -1), 1);

        // randomized traffic
        clear_queues(); clear_logs();
        do_reset();
        for (int p = 0; p < N; p++) begin
            int nb;
            nb = $urandom_range(2, 4);
            for (int b = 0; b < nb; b++) push_burst(p, $urandom_range(1, 20), 1'b1);
        end
        push_burst(1, MB, 1'b1);
        rnd_mode = 1'b1;
        drive();
        run_until_empty(5000);
        rnd_mode = 1'b0; full = 1'b0;
        begin
            int exp_n;
            exp_n = 0;
            for (int p = 0; p < N; p++) exp_n += sent[p].size();
            chk("rnd_nwrites", 64'(wlog_d.size()), 64'(exp_n));
        end
        for (int p = 0; p < N; p++) begin
            int k;
            k = 0;
            for (int w = 0; w < wlog_d.size(); w++) begin
                if (wlog_id[w] == p && k < sent[p].size()) begin
                    chk("rnd_order", 64'(wlog_d[w]), 64'(sent[p][k]));
                    k++;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
